// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Multi-cycle instruction sequencer for the RAT CPU. Steps through
//   INIT -> FETCH -> EXEC -> [WAIT] -> FETCH, and inserts an INTR cycle at an
//   instruction boundary when an enabled interrupt is pending. Each of the
//   NUM_INT request channels has a sticky pending bit. Bit 0 has the highest
//   priority, and one channel is acknowledged per INTR cycle.
//
// Ports
//   CLK          clock, rising edge
//   RESET        asynchronous active-low reset
//   INT_REQ      level interrupt requests, bit 0 = highest priority
//   IS_MEM_OP    decoder: current instruction touches scratch/IO memory
//   INT_EN_SET   decoder: SEI / RETIE executing (honoured in EXEC only)
//   INT_EN_CLR   decoder: CLI / RETID executing (honoured in EXEC only, wins)
//   RST          datapath reset pulse (INIT)
//   IR_LD        load instruction register (FETCH)
//   PC_INC       increment PC (FETCH)
//   EXEC_EN      decoder write strobes valid (EXEC)
//   MEM_HOLD     memory wait state, datapath holds (WAIT)
//   PC_LD        load PC from PC_MUX_SEL source (INTR)
//   PC_MUX_SEL   2'b10 selects INT_VEC during INTR, else 2'b00
//   INT_VEC      vector of the acknowledged channel during INTR, else 0
//   PUSH_PC      push PC / decrement SP (INTR)
//   FLG_SHAD_LD  copy C/Z to shadow flags (INTR)
//   INT_ACK      one-hot acknowledge (INTR)
//   I_FLAG       interrupt enable status
//   INT_PENDING  OR of the pending bits (registered)
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int              NUM_INT  = 4,
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] VEC_BASE = PC_W'(10'h3FF),
    parameter int              MEM_WAIT = 0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_INT-1:0] INT_REQ,
    input  logic               IS_MEM_OP,
    input  logic               INT_EN_SET,
    input  logic               INT_EN_CLR,
    output logic               RST,
    output logic               IR_LD,
    output logic               PC_INC,
    output logic               EXEC_EN,
    output logic               MEM_HOLD,
    output logic               PC_LD,
    output logic [1:0]         PC_MUX_SEL,
    output logic [PC_W-1:0]    INT_VEC,
    output logic               PUSH_PC,
    output logic               FLG_SHAD_LD,
    output logic [NUM_INT-1:0] INT_ACK,
    output logic               I_FLAG,
    output logic               INT_PENDING
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    // The counter is loaded with MEM_WAIT-1 on entry, so WAIT spans MEM_WAIT cycles.
    localparam int          WAIT_LOAD_I = (MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0;
    localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_LOAD_I);

    state_t               state_reg, state_next;
    logic [NUM_INT-1:0]   pend_reg, pend_next;
    logic                 i_flag_reg, i_flag_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic                 rst_strobe;

    // Priority select: first_pend has only the lowest-index pending bit set.
    logic [NUM_INT-1:0]   first_pend;
    logic [NUM_INT:0]     lower_pend;
    logic [PC_W-1:0]      vec_sel;

    assign lower_pend[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_prio
            assign first_pend[gi]     = pend_reg[gi] & ~lower_pend[gi];
            assign lower_pend[gi + 1] = lower_pend[gi] | pend_reg[gi];
        end
    endgenerate

    always_comb begin
        vec_sel = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            if (first_pend[i]) begin
                vec_sel = VEC_BASE - PC_W'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg  <= ST_INIT;
            pend_reg   <= '0;
            i_flag_reg <= 1'b0;
            cnt_reg    <= 4'd0;
        end else begin
            state_reg  <= state_next;
            pend_reg   <= pend_next;
            i_flag_reg <= i_flag_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        i_flag_next = i_flag_reg;
        rst_strobe  = 1'b0;
        IR_LD       = 1'b0;
        PC_INC      = 1'b0;
        EXEC_EN     = 1'b0;
        MEM_HOLD    = 1'b0;
        PC_LD       = 1'b0;
        PC_MUX_SEL  = 2'b00;
        INT_VEC     = '0;
        PUSH_PC     = 1'b0;
        FLG_SHAD_LD = 1'b0;
        INT_ACK     = '0;

        case (state_reg)
            ST_INIT: begin
                rst_strobe = 1'b1;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                IR_LD      = 1'b1;
                PC_INC     = 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                EXEC_EN = 1'b1;
                if (INT_EN_CLR) begin
                    i_flag_next = 1'b0;
                end else if (INT_EN_SET) begin
                    i_flag_next = 1'b1;
                end
                if (IS_MEM_OP && (MEM_WAIT > 0)) begin
                    state_next = ST_WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    // Use the post-SEI/CLI enable so the instruction's own boundary sees it.
                    state_next = (|(pend_reg & {NUM_INT{i_flag_next}})) ? ST_INTR : ST_FETCH;
                end
            end
            ST_WAIT: begin
                MEM_HOLD = 1'b1;
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next = (|(pend_reg & {NUM_INT{i_flag_next}})) ? ST_INTR : ST_FETCH;
                end
            end
            ST_INTR: begin
                PC_LD       = 1'b1;
                PC_MUX_SEL  = 2'b10;
                PUSH_PC     = 1'b1;
                FLG_SHAD_LD = 1'b1;
                INT_ACK     = first_pend;
                INT_VEC     = vec_sel;
                i_flag_next = 1'b0;
                state_next  = ST_FETCH;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase

        // A request still high during its own ack cycle re-pends.
        pend_next = (pend_reg & ~INT_ACK) | INT_REQ;
    end

    // The INIT pulse is masked while reset is held, so all outputs read 0 in reset.
    assign RST         = rst_strobe & RESET;
    assign I_FLAG      = i_flag_reg;
    assign INT_PENDING = |pend_reg;

endmodule
